// File: rtl/hamming_pkg.sv
// Shared (7,4) Hamming code definitions: codeword bit positions, parity coverage
// masks and the syndrome-to-bit correction table used by encoder and corrector.
package hamming_pkg;

  localparam int unsigned MsgBits = 4;
  localparam int unsigned CwBits  = 7;
  localparam int unsigned SynBits = 3;

  typedef logic [CwBits-1:0]  cw_t;
  typedef logic [MsgBits-1:0] msg_t;
  typedef logic [SynBits-1:0] syn_t;

  localparam int unsigned PosM0 = 0;
  localparam int unsigned PosM1 = 1;
  localparam int unsigned PosM2 = 2;
  localparam int unsigned PosP0 = 3;
  localparam int unsigned PosM3 = 4;
  localparam int unsigned PosP1 = 5;
  localparam int unsigned PosP2 = 6;

  // Each mask selects one parity bit plus the message bits it covers.
  localparam cw_t P0Mask = 7'b0011101;
  localparam cw_t P1Mask = 7'b0110011;
  localparam cw_t P2Mask = 7'b1000111;

  // Entry 0 is never used: a zero syndrome flips nothing.
  localparam int unsigned SynToPos [8] = '{0, PosP0, PosP1, PosM3, PosP2, PosM2, PosM1, PosM0};

  function automatic cw_t encode(msg_t m);
    cw_t c;
    c        = '0;
    c[PosM0] = m[0];
    c[PosM1] = m[1];
    c[PosM2] = m[2];
    c[PosM3] = m[3];
    c[PosP0] = ^(c & P0Mask);
    c[PosP1] = ^(c & P1Mask);
    c[PosP2] = ^(c & P2Mask);
    return c;
  endfunction

  function automatic syn_t calc_syndrome(cw_t c);
    return {^(c & P2Mask), ^(c & P1Mask), ^(c & P0Mask)};
  endfunction

  function automatic cw_t flip_mask(syn_t s);
    if (s == '0) begin
      return '0;
    end
    return cw_t'(1) << SynToPos[s];
  endfunction

  function automatic msg_t extract_msg(cw_t c);
    return {c[PosM3], c[PosM2], c[PosM1], c[PosM0]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational (7,4) decode: syndrome, single-bit correction and message extraction.
import hamming_pkg::*;

module hamming_syndrome (
  input  logic [CwBits-1:0]  codeword,
  output logic [SynBits-1:0] syndrome,
  output logic [MsgBits-1:0] data,
  output logic               err
);

  cw_t corrected;

  always_comb begin
    syndrome  = calc_syndrome(codeword);
    corrected = codeword ^ flip_mask(syndrome);
    data      = extract_msg(corrected);
    err       = (syndrome != '0);
  end

endmodule

// File: rtl/hamming_corrector.sv
// Registered (7,4) Hamming corrector with valid/ready handshake, one-entry output
// register and a saturating count of corrected words.
import hamming_pkg::*;

module hamming_corrector #(
  parameter int unsigned CNT_BITS  = 16,
  parameter int unsigned DATA_BITS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [6:0]          DATA_IN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [3:0]          DATA_OUT,
  output logic                ERR_FLAG,
  output logic [2:0]          SYNDROME,
  input  logic                CNT_CLR,
  output logic [CNT_BITS-1:0] ERR_COUNT
);

  if (DATA_BITS != 4) begin : gen_bad_data_bits
    $fatal(1, "hamming_corrector: DATA_BITS must be 4");
  end

  localparam logic [CNT_BITS-1:0] CntMax = {CNT_BITS{1'b1}};

  logic [SynBits-1:0] dec_syn;
  logic [MsgBits-1:0] dec_data;
  logic               dec_err;

  hamming_syndrome u_syndrome (
    .codeword (DATA_IN),
    .syndrome (dec_syn),
    .data     (dec_data),
    .err      (dec_err)
  );

  logic                valid_q, valid_d;
  logic [MsgBits-1:0]  data_q, data_d;
  logic                flag_q, flag_d;
  logic [SynBits-1:0]  syn_q, syn_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                accept;

  // Output slot frees up in the same cycle it drains, giving 1 word/cycle.
  assign IN_READY = !valid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;
    syn_d   = syn_q;
    cnt_d   = cnt_q;

    if (accept) begin
      valid_d = 1'b1;
      data_d  = dec_data;
      flag_d  = dec_err;
      syn_d   = dec_syn;
    end else if (OUT_READY) begin
      valid_d = 1'b0;
    end

    // Clear wins over a coincident erroneous acceptance.
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (accept && dec_err && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      syn_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      syn_q   <= syn_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign DATA_OUT  = data_q;
  assign ERR_FLAG  = flag_q;
  assign SYNDROME  = syn_q;
  assign ERR_COUNT = cnt_q;

endmodule
